// File: rtl/scanner_node_if.sv
// -----------------------------------------------------------------------------
// scanner_node_if
//
// Purpose:
//   Sample transfer port of the scanner node. The node presents one buffered
//   sample per cycle while it drains, and the downstream side paces it with
//   a ready signal. A sample is consumed on every rising edge where both
//   valid and ready are high.
//
// Signals:
//   valid  node -> sink  a sample is being presented
//   ready  sink -> node  the sink accepts the presented sample this cycle
//   index  node -> sink  buffer index of the presented sample (0 when !valid)
//
// Modports:
//   master  the scanner node (drives valid/index, observes ready)
//   slave   the downstream consumer (observes valid/index, drives ready)
// -----------------------------------------------------------------------------
interface scanner_node_if #(
  parameter int CW = 4
);

  logic          valid;
  logic          ready;
  logic [CW-1:0] index;

  modport master (
    output valid,
    output index,
    input  ready
  );

  modport slave (
    input  valid,
    input  index,
    output ready
  );

endinterface : scanner_node_if

// File: rtl/scanner_node.sv
// -----------------------------------------------------------------------------
// scanner_node
//
// Purpose:
//   One node of a multi-scanner system. It walks the lifecycle
//   LOWPOWER -> STANDBY -> COLLECTING -> IDLE -> TRANSFERRING/FLUSHING ->
//   LOWPOWER, fills a buffer of DEPTH samples while collecting, and drains it
//   through a valid/ready transfer port. While collecting it emits peer
//   commands on the 2-bit comm bus at configurable fill levels so that a
//   cross-connected peer can be woken, started or flushed.
//
//   Every output is a Moore output decoded from the registered state, fill
//   level and flush timer; no input reaches an output combinationally.
//
// Parameters:
//   ID            instance identifier, no effect on logic
//   DEPTH         buffer capacity in samples (4 .. 2**CW-1)
//   CW            width of fill and transfer index
//   FLUSH_AT      fill level at which START_FLUSH is emitted (< DEPTH)
//   STANDBY_AT    fill level at which GO_TO_STANDBY is emitted (< DEPTH)
//   SCAN_AT       fill level at which START_SCAN is emitted (< DEPTH)
//   FLUSH_CYCLES  cycles spent in FLUSHING (1 .. 2**CW-1)
//
// Ports:
//   clk              in   rising-edge clock
//   reset            in   synchronous, active-low reset
//   i_user_power     in   manual wake, LOWPOWER -> STANDBY
//   i_user_scan      in   manual scan start, STANDBY -> COLLECTING
//   i_user_transfer  in   manual transfer request in IDLE
//   i_rx_comm        in   command from a peer (see comm_t)
//   o_tx_comm        out  command to a peer (see comm_t)
//   o_state          out  present lifecycle state code (see state_t)
//   o_fill           out  buffer occupancy, 0 .. DEPTH
//   o_busy           out  high in COLLECTING, TRANSFERRING or FLUSHING
//   xfer             if   transfer port, master side
// -----------------------------------------------------------------------------
module scanner_node #(
  parameter int ID           = 0,
  parameter int DEPTH        = 10,
  parameter int CW           = 4,
  parameter int FLUSH_AT     = 5,
  parameter int STANDBY_AT   = 7,
  parameter int SCAN_AT      = 8,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_user_power,
  input  logic              i_user_scan,
  input  logic              i_user_transfer,
  input  logic [1:0]        i_rx_comm,
  output logic [1:0]        o_tx_comm,
  output logic [2:0]        o_state,
  output logic [CW-1:0]     o_fill,
  output logic              o_busy,
  scanner_node_if.master    xfer
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_LOWPOWER     = 3'd0,
    S_STANDBY      = 3'd1,
    S_COLLECTING   = 3'd2,
    S_IDLE         = 3'd3,
    S_TRANSFERRING = 3'd4,
    S_FLUSHING     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    COMM_INACTIVE   = 2'b00,
    COMM_GO_STANDBY = 2'b01,
    COMM_START_SCAN = 2'b10,
    COMM_START_FLSH = 2'b11
  } comm_t;

  // Parameter-derived constants, sized to the fill/timer width once so the
  // compares below stay width-clean.
  localparam logic [CW-1:0] L_ONE        = CW'(1);
  localparam logic [CW-1:0] L_DEPTH      = CW'(DEPTH);
  localparam logic [CW-1:0] L_DEPTH_M1   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] L_FLUSH_AT   = CW'(FLUSH_AT);
  localparam logic [CW-1:0] L_STANDBY_AT = CW'(STANDBY_AT);
  localparam logic [CW-1:0] L_SCAN_AT    = CW'(SCAN_AT);
  localparam logic [CW-1:0] L_FLUSH_LAST = CW'(FLUSH_CYCLES - 1);

  // A parameter set outside the legal ranges shows up as this named scope in
  // the elaborated hierarchy; it carries no logic. ID is folded in so that a
  // negative identifier is flagged the same way.
  if ((DEPTH < 4) || ((2 ** CW) <= DEPTH) ||
      (FLUSH_AT >= DEPTH) || (STANDBY_AT >= DEPTH) || (SCAN_AT >= DEPTH) ||
      (FLUSH_CYCLES < 1) || (FLUSH_CYCLES >= (2 ** CW)) || (ID < 0))
  begin : g_illegal_parameters
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [CW-1:0]   r_fill;
  logic [CW-1:0]   r_timer;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_fill_nxt;
  logic [CW-1:0]   w_timer_nxt;

  // NOTE: reset is sampled only at the clock edge, so it sits inside the
  // edge-triggered block rather than in its sensitivity list.
  // NOTE: state registers use non-blocking assignments so every register
  // updates from the values that existed before the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_LOWPOWER;
      r_fill  <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_timer_nxt = r_timer;

    case (r_state)
      S_LOWPOWER: begin
        if (i_user_power || (i_rx_comm == COMM_GO_STANDBY)) begin
          w_state_nxt = S_STANDBY;
        end
      end

      S_STANDBY: begin
        if (i_user_scan || (i_rx_comm == COMM_START_SCAN)) begin
          w_state_nxt = S_COLLECTING;
          w_fill_nxt  = '0;
        end
      end

      // One sample per cycle; the last increment lands exactly on DEPTH so
      // the node spends DEPTH cycles here. Inputs are deliberately ignored.
      S_COLLECTING: begin
        if (r_fill >= L_DEPTH_M1) begin
          w_state_nxt = S_IDLE;
          w_fill_nxt  = L_DEPTH;
        end else begin
          w_fill_nxt  = r_fill + L_ONE;
        end
      end

      // A local transfer request wins over a peer flush arriving together.
      S_IDLE: begin
        if (i_user_transfer) begin
          w_state_nxt = S_TRANSFERRING;
        end else if (i_rx_comm == COMM_START_FLSH) begin
          w_state_nxt = S_FLUSHING;
          w_fill_nxt  = '0;
          w_timer_nxt = '0;
        end
      end

      // Drain one sample per accepted handshake. The <= compare also catches
      // an (unreachable) empty buffer so fill can never wrap below zero.
      S_TRANSFERRING: begin
        if (xfer.ready) begin
          if (r_fill <= L_ONE) begin
            w_state_nxt = S_LOWPOWER;
            w_fill_nxt  = '0;
          end else begin
            w_fill_nxt  = r_fill - L_ONE;
          end
        end
      end

      S_FLUSHING: begin
        w_fill_nxt = '0;
        if (r_timer >= L_FLUSH_LAST) begin
          w_state_nxt = S_LOWPOWER;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + L_ONE;
        end
      end

      // Codes 6 and 7 recover to a clean LOWPOWER.
      default: begin
        w_state_nxt = S_LOWPOWER;
        w_fill_nxt  = '0;
        w_timer_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    o_tx_comm   = COMM_INACTIVE;
    o_busy      = 1'b0;
    xfer.valid  = 1'b0;
    xfer.index  = '0;

    case (r_state)
      // Peer commands fire at fixed fill levels; when levels coincide the
      // flush command outranks scan, which outranks standby.
      S_COLLECTING: begin
        o_busy = 1'b1;
        if (r_fill == L_FLUSH_AT) begin
          o_tx_comm = COMM_START_FLSH;
        end else if (r_fill == L_SCAN_AT) begin
          o_tx_comm = COMM_START_SCAN;
        end else if (r_fill == L_STANDBY_AT) begin
          o_tx_comm = COMM_GO_STANDBY;
        end
      end

      // The oldest remaining sample is DEPTH - fill, so the index runs
      // 0 .. DEPTH-1 as the buffer drains and freezes during a stall.
      S_TRANSFERRING: begin
        o_busy     = 1'b1;
        xfer.valid = 1'b1;
        xfer.index = L_DEPTH - r_fill;
      end

      S_FLUSHING: begin
        o_busy = 1'b1;
      end

      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_state = r_state;
  assign o_fill  = r_fill;

endmodule : scanner_node

// File: tb/tb_scanner_node.sv
// -----------------------------------------------------------------------------
// tb_scanner_node
//
// Directed bench for scanner_node. Three instances:
//   u_dut  default parameters, every input driven directly by the bench
//   u_a    DEPTH=12 node, comm bus cross-connected with u_b
//   u_b    default node, woken and started only by u_a's commands
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, i.e. well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_scanner_node;

  localparam int CW         = 4;
  localparam int DEPTH      = 10;
  localparam int DEPTH_A    = 12;
  localparam int FLUSH_AT   = 5;
  localparam int STANDBY_AT = 7;
  localparam int SCAN_AT    = 8;

  logic       clk;
  logic       reset;

  // Directly driven node.
  logic       d_power, d_scan, d_transfer;
  logic [1:0] d_rx;
  logic [1:0] d_tx;
  logic [2:0] d_state;
  logic [CW-1:0] d_fill;
  logic       d_busy;

  // Cross-connected pair.
  logic       a_power, a_scan;
  logic [1:0] a_tx, b_tx;
  logic [2:0] a_state, b_state;
  logic [CW-1:0] a_fill, b_fill;
  logic       a_busy, b_busy;

  int n_vec;
  int n_miss;

  // Scoreboard of transfer indices still owed by the DUT.
  int exp_q[$];

  scanner_node_if #(.CW(CW)) u_if_dut ();
  scanner_node_if #(.CW(CW)) u_if_a ();
  scanner_node_if #(.CW(CW)) u_if_b ();

  scanner_node #(.ID(0), .DEPTH(DEPTH), .CW(CW)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .i_user_power    (d_power),
    .i_user_scan     (d_scan),
    .i_user_transfer (d_transfer),
    .i_rx_comm       (d_rx),
    .o_tx_comm       (d_tx),
    .o_state         (d_state),
    .o_fill          (d_fill),
    .o_busy          (d_busy),
    .xfer            (u_if_dut.master)
  );

  scanner_node #(.ID(1), .DEPTH(DEPTH_A), .CW(CW)) u_a (
    .clk             (clk),
    .reset           (reset),
    .i_user_power    (a_power),
    .i_user_scan     (a_scan),
    .i_user_transfer (1'b0),
    .i_rx_comm       (b_tx),
    .o_tx_comm       (a_tx),
    .o_state         (a_state),
    .o_fill          (a_fill),
    .o_busy          (a_busy),
    .xfer            (u_if_a.master)
  );

  scanner_node #(.ID(2), .DEPTH(DEPTH), .CW(CW)) u_b (
    .clk             (clk),
    .reset           (reset),
    .i_user_power    (1'b0),
    .i_user_scan     (1'b0),
    .i_user_transfer (1'b0),
    .i_rx_comm       (a_tx),
    .o_tx_comm       (b_tx),
    .o_state         (b_state),
    .o_fill          (b_fill),
    .o_busy          (b_busy),
    .xfer            (u_if_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a wedged run still terminates with a visible failure.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed=running required=done");
    $fatal(1, "time limit");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Peer command a default node should emit at a given fill while collecting.
  function automatic logic [1:0] exp_tx(input int f);
    if (f == FLUSH_AT)        return 2'b11;
    else if (f == SCAN_AT)    return 2'b10;
    else if (f == STANDBY_AT) return 2'b01;
    else                      return 2'b00;
  endfunction

  // Walk the directly driven node from LOWPOWER to IDLE.
  task automatic go_idle();
    d_power = 1'b1;
    tick();
    d_power = 1'b0;
    d_scan  = 1'b1;
    tick();
    d_scan  = 1'b0;
    tick(DEPTH);
  endtask

  initial begin
    int accepted;
    int exp_a_state, exp_a_fill, exp_b_state, exp_b_fill;

    n_vec    = 0;
    n_miss   = 0;
    accepted = 0;

    // ---------------- reset with every input asserted ----------------
    reset      = 1'b0;
    d_power    = 1'b1;
    d_scan     = 1'b1;
    d_transfer = 1'b1;
    d_rx       = 2'b11;
    a_power    = 1'b1;
    a_scan     = 1'b1;
    u_if_dut.ready = 1'b1;
    u_if_a.ready   = 1'b0;
    u_if_b.ready   = 1'b0;
    tick(2);
    check("rst_state", 32'(d_state), 0);
    check("rst_fill",  32'(d_fill),  0);
    check("rst_tx",    32'(d_tx),    0);
    check("rst_valid", 32'(u_if_dut.valid), 0);
    check("rst_busy",  32'(d_busy),  0);

    reset      = 1'b1;
    d_power    = 1'b0;
    d_scan     = 1'b0;
    d_transfer = 1'b0;
    d_rx       = 2'b00;
    a_power    = 1'b0;
    a_scan     = 1'b0;
    u_if_dut.ready = 1'b0;
    tick(2);
    check("post_rst_state", 32'(d_state), 0);

    // ---------------- full collect sequence ----------------
    d_power = 1'b1;
    tick();
    d_power = 1'b0;
    check("wake_state", 32'(d_state), 1);
    d_scan = 1'b1;
    tick();
    d_scan = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("col_state_%0d", k), 32'(d_state), 2);
      check($sformatf("col_fill_%0d", k),  32'(d_fill),  32'(k));
      check($sformatf("col_busy_%0d", k),  32'(d_busy),  1);
      check($sformatf("col_tx_%0d", k),    32'(d_tx),    32'(exp_tx(k)));
      tick();
    end
    check("idle_state", 32'(d_state), 3);
    check("idle_fill",  32'(d_fill),  DEPTH);
    check("idle_busy",  32'(d_busy),  0);
    check("idle_tx",    32'(d_tx),    0);

    // Non-flush peer commands are ignored in IDLE.
    d_rx = 2'b10;
    tick();
    d_rx = 2'b00;
    check("idle_ignore_rx", 32'(d_state), 3);

    // ---------------- transfer with 1010... backpressure ----------------
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(i);
    d_transfer = 1'b1;
    tick();
    d_transfer = 1'b0;
    check("xfer_enter", 32'(d_state), 4);
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (d_state !== 3'd4) break;
      u_if_dut.ready = (cyc % 2 == 0);
      check("xfer_valid", 32'(u_if_dut.valid), 1);
      check("xfer_fill",  32'(d_fill), 32'(DEPTH - accepted));
      if (exp_q.size() == 0) begin
        check("xfer_extra_sample", 32'(u_if_dut.index), 32'hFFFF_FFFF);
      end else begin
        check("xfer_index", 32'(u_if_dut.index), 32'(exp_q[0]));
        if (u_if_dut.ready) begin
          void'(exp_q.pop_front());
          accepted++;
        end
      end
      tick();
    end
    u_if_dut.ready = 1'b0;
    check("xfer_count",      32'(accepted), DEPTH);
    check("xfer_q_empty",    32'(exp_q.size()), 0);
    check("xfer_done_state", 32'(d_state), 0);
    check("xfer_done_fill",  32'(d_fill),  0);
    check("xfer_done_valid", 32'(u_if_dut.valid), 0);
    check("xfer_done_index", 32'(u_if_dut.index), 0);

    // ---------------- peer flush ----------------
    go_idle();
    check("flush_pre_state", 32'(d_state), 3);
    d_rx = 2'b11;
    tick();
    d_rx = 2'b00;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("flush_state_%0d", i), 32'(d_state), 5);
      check($sformatf("flush_fill_%0d", i),  32'(d_fill),  0);
      check($sformatf("flush_busy_%0d", i),  32'(d_busy),  1);
      tick();
    end
    check("flush_done_state", 32'(d_state), 0);

    // Transfer request beats a simultaneous peer flush.
    go_idle();
    d_transfer = 1'b1;
    d_rx       = 2'b11;
    tick();
    d_transfer = 1'b0;
    d_rx       = 2'b00;
    check("prio_state", 32'(d_state), 4);

    // ---------------- reset mid-transfer ----------------
    u_if_dut.ready = 1'b1;
    tick(4);
    check("mid_state", 32'(d_state), 4);
    check("mid_fill",  32'(d_fill),  6);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    u_if_dut.ready = 1'b0;
    check("mid_rst_state", 32'(d_state), 0);
    check("mid_rst_fill",  32'(d_fill),  0);
    check("mid_rst_valid", 32'(u_if_dut.valid), 0);

    // ---------------- peer wake chain (A has DEPTH=12) ----------------
    check("chain_b_start", 32'(b_state), 0);
    a_power = 1'b1;
    tick();
    a_power = 1'b0;
    check("chain_a_wake", 32'(a_state), 1);
    a_scan = 1'b1;
    tick();
    a_scan = 1'b0;
    // k counts cycles since A entered COLLECTING. A emits GO_TO_STANDBY at
    // fill 7 and START_SCAN at fill 8; B's START_FLUSH at its fill 5 (k=14)
    // catches A in IDLE, while A's own flush at k=5 finds B in LOWPOWER.
    for (int k = 0; k < 20; k++) begin
      if (k < DEPTH_A) begin
        exp_a_state = 2;  exp_a_fill = k;
      end else if (k < 15) begin
        exp_a_state = 3;  exp_a_fill = DEPTH_A;
      end else if (k < 18) begin
        exp_a_state = 5;  exp_a_fill = 0;
      end else begin
        exp_a_state = 0;  exp_a_fill = 0;
      end
      if (k < 8) begin
        exp_b_state = 0;  exp_b_fill = 0;
      end else if (k == 8) begin
        exp_b_state = 1;  exp_b_fill = 0;
      end else if (k < 19) begin
        exp_b_state = 2;  exp_b_fill = k - 9;
      end else begin
        exp_b_state = 3;  exp_b_fill = DEPTH;
      end
      check($sformatf("chain_a_state_%0d", k), 32'(a_state), 32'(exp_a_state));
      check($sformatf("chain_a_fill_%0d", k),  32'(a_fill),  32'(exp_a_fill));
      check($sformatf("chain_b_state_%0d", k), 32'(b_state), 32'(exp_b_state));
      check($sformatf("chain_b_fill_%0d", k),  32'(b_fill),  32'(exp_b_fill));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_scanner_node
